// File: rtl/icache_refill_ctrl_pkg.sv
// ============================================================================
// Module  : icache_refill_ctrl_pkg
// Purpose : Shared AXI types and widths plus the ICACHE refill controller
//           state encoding and line geometry.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package icache_refill_ctrl_pkg;

  // AXI widths shared by the bus-facing blocks
  localparam int AXI_ID_WIDTH   = 4;
  localparam int AXI_ADDR_WIDTH = 32;
  localparam int AXI_DATA_WIDTH = 32;
  localparam int AXI_LEN_WIDTH  = 8;

  typedef enum logic [1:0] {
    AXI_BURST_FIXED = 2'b00,
    AXI_BURST_INCR  = 2'b01,
    AXI_BURST_WRAP  = 2'b10
  } axi_burst_type_t;

  typedef enum logic [1:0] {
    AXI_RESP_OKAY   = 2'b00,
    AXI_RESP_EXOKAY = 2'b01,
    AXI_RESP_SLVERR = 2'b10,
    AXI_RESP_DECERR = 2'b11
  } axi_resp_t;

  typedef enum logic [2:0] {
    AXI_SIZE_1B   = 3'd0,
    AXI_SIZE_2B   = 3'd1,
    AXI_SIZE_4B   = 3'd2,
    AXI_SIZE_8B   = 3'd3,
    AXI_SIZE_16B  = 3'd4,
    AXI_SIZE_32B  = 3'd5,
    AXI_SIZE_64B  = 3'd6,
    AXI_SIZE_128B = 3'd7
  } axi_size_t;

  // ICACHE line geometry
  localparam int ICACHE_LINE_SIZE  = 32;
  localparam int ICACHE_LINE_WORDS = ICACHE_LINE_SIZE / 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    AREQ  = 2'd1,
    RDATA = 2'd2,
    RESP  = 2'd3
  } icache_refill_state_t;

endpackage

`default_nettype wire

// File: rtl/icache_refill_ctrl.sv
// ============================================================================
// Module  : icache_refill_ctrl
// Purpose : Sequences one ICACHE line refill at a time over AXI AR/R. A miss
//           is latched, a single INCR burst covering the whole line is
//           issued, beats are gathered into a line buffer and the completed
//           line is returned with a sticky error flag.
// Ports   : clk, rst_n                      - clock, async active-low reset
//           miss_valid_i/ready_o/addr_i     - miss request from the cache
//           line_valid_o/ready_i/addr_o/
//           line_data_o/err_o               - completed line to the cache
//           axi_ar*                         - AXI read address channel
//           axi_r*                          - AXI read data channel
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module icache_refill_ctrl
  import icache_refill_ctrl_pkg::*;
#(
  parameter logic [AXI_ID_WIDTH-1:0] AXI_ID = '0,
  parameter int                      LINE_B = ICACHE_LINE_SIZE,
  parameter int                      BEATS  = LINE_B / 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  // miss request
  input  logic                    miss_valid_i,
  output logic                    miss_ready_o,
  input  logic [31:0]             miss_addr_i,
  // line result
  output logic                    line_valid_o,
  input  logic                    line_ready_i,
  output logic [31:0]             line_addr_o,
  output logic [LINE_B*8-1:0]     line_data_o,
  output logic                    line_err_o,
  // AXI read address channel
  output logic [AXI_ID_WIDTH-1:0] axi_arid,
  output logic [31:0]             axi_araddr,
  output logic [7:0]              axi_arlen,
  output logic [2:0]              axi_arsize,
  output logic [1:0]              axi_arburst,
  output logic                    axi_arvalid,
  input  logic                    axi_arready,
  // AXI read data channel
  input  logic [AXI_ID_WIDTH-1:0] axi_rid,
  input  logic [31:0]             axi_rdata,
  input  logic [1:0]              axi_rresp,
  input  logic                    axi_rlast,
  input  logic                    axi_rvalid,
  output logic                    axi_rready
);

  // A one-beat line still needs a one-bit counter
  localparam int                CNT_W    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(BEATS - 1);
  localparam logic [31:0]       LINE_MSK = ~(32'(LINE_B) - 32'd1);

  icache_refill_state_t state, state_nxt;

  logic [CNT_W-1:0] beat_cnt;
  logic             err;
  logic [31:0]      addr;
  logic [31:0]      line_buf [BEATS];

  logic      miss_hs;
  logic      beat_hs;
  logic      last_beat;
  logic      beat_err;
  axi_resp_t rresp;

  assign miss_hs   = miss_valid_i & miss_ready_o;
  assign beat_hs   = axi_rvalid & axi_rready;
  assign last_beat = (beat_cnt == LAST_CNT);
  assign rresp     = axi_resp_t'(axi_rresp);

  // Any error source marks the line; the burst itself is always drained to
  // BEATS beats because the interconnect still owes us the remaining data.
  assign beat_err = (rresp == AXI_RESP_SLVERR) || (rresp == AXI_RESP_DECERR) ||
                    (axi_rid != AXI_ID) || (axi_rlast != last_beat);

  // --------------------------------------------------------------------------
  // State register and datapath
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      beat_cnt <= '0;
      err      <= 1'b0;
      addr     <= '0;
      for (int i = 0; i < BEATS; i++) begin
        line_buf[i] <= '0;
      end
    end else begin
      state <= state_nxt;
      if (miss_hs) begin
        addr     <= miss_addr_i & LINE_MSK;
        err      <= 1'b0;
        beat_cnt <= '0;
      end
      if (beat_hs) begin
        line_buf[beat_cnt] <= axi_rdata;
        beat_cnt           <= last_beat ? '0 : beat_cnt + CNT_W'(1);
        if (beat_err) begin
          err <= 1'b1;
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Next state and handshake outputs; all outputs are decoded from the state
  // register only, so line_valid_o has no path from line_ready_i.
  // --------------------------------------------------------------------------
  always_comb begin
    state_nxt    = state;
    miss_ready_o = 1'b0;
    axi_arvalid  = 1'b0;
    axi_rready   = 1'b0;
    line_valid_o = 1'b0;
    unique case (state)
      IDLE: begin
        miss_ready_o = 1'b1;
        if (miss_valid_i) begin
          state_nxt = AREQ;
        end
      end
      AREQ: begin
        axi_arvalid = 1'b1;
        if (axi_arready) begin
          state_nxt = RDATA;
        end
      end
      RDATA: begin
        axi_rready = 1'b1;
        if (axi_rvalid && last_beat) begin
          state_nxt = RESP;
        end
      end
      RESP: begin
        line_valid_o = 1'b1;
        if (line_ready_i) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Fixed AR fields; address comes from the latched, line-aligned miss
  assign axi_arid    = AXI_ID;
  assign axi_araddr  = addr;
  assign axi_arlen   = 8'(BEATS - 1);
  assign axi_arsize  = AXI_SIZE_4B;
  assign axi_arburst = AXI_BURST_INCR;

  assign line_addr_o = addr;
  assign line_err_o  = err;

  for (genvar k = 0; k < BEATS; k++) begin : g_pack
    assign line_data_o[32*k +: 32] = line_buf[k];
  end

endmodule

`default_nettype wire

// File: tb/tb_icache_refill_ctrl.sv
// ============================================================================
// Module  : tb_icache_refill_ctrl
// Purpose : Self-checking bench for icache_refill_ctrl. A table of refill
//           scenarios is replayed through an AXI slave driven by tasks, then
//           hand-written sequences cover RESP back-pressure with a pending
//           miss and a reset in the middle of a burst.
// Revision: 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_icache_refill_ctrl;
  import icache_refill_ctrl_pkg::*;

  localparam int BEATS  = 8;
  localparam int LINE_B = 32;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         miss_valid_i, miss_ready_o;
  logic [31:0]  miss_addr_i;
  logic         line_valid_o, line_ready_i;
  logic [31:0]  line_addr_o;
  logic [255:0] line_data_o;
  logic         line_err_o;
  logic [3:0]   axi_arid;
  logic [31:0]  axi_araddr;
  logic [7:0]   axi_arlen;
  logic [2:0]   axi_arsize;
  logic [1:0]   axi_arburst;
  logic         axi_arvalid, axi_arready;
  logic [3:0]   axi_rid;
  logic [31:0]  axi_rdata;
  logic [1:0]   axi_rresp;
  logic         axi_rlast, axi_rvalid, axi_rready;

  always #5 clk = ~clk;

  icache_refill_ctrl #(.AXI_ID(4'h0), .LINE_B(LINE_B), .BEATS(BEATS)) dut (
    .clk(clk), .rst_n(rst_n),
    .miss_valid_i(miss_valid_i), .miss_ready_o(miss_ready_o), .miss_addr_i(miss_addr_i),
    .line_valid_o(line_valid_o), .line_ready_i(line_ready_i), .line_addr_o(line_addr_o),
    .line_data_o(line_data_o), .line_err_o(line_err_o),
    .axi_arid(axi_arid), .axi_araddr(axi_araddr), .axi_arlen(axi_arlen),
    .axi_arsize(axi_arsize), .axi_arburst(axi_arburst), .axi_arvalid(axi_arvalid),
    .axi_arready(axi_arready), .axi_rid(axi_rid), .axi_rdata(axi_rdata),
    .axi_rresp(axi_rresp), .axi_rlast(axi_rlast), .axi_rvalid(axi_rvalid),
    .axi_rready(axi_rready)
  );

  typedef struct {
    logic [31:0] addr;
    int          ar_delay;
    bit          gap;
    int          resp_beat;
    logic [1:0]  resp_code;
    int          early_last;
    int          bad_id_beat;
    bit          drop_last;
    logic [31:0] base;
    logic [31:0] exp_araddr;
    bit          exp_err;
    int          exp_lat;
  } vec_t;

  vec_t vecs[9];
  int   n_chk  = 0;
  int   n_pass = 0;
  int   cyc;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_miss(input logic [31:0] a);
    int w = 0;
    while (miss_ready_o !== 1'b1 && w < 20) begin
      tick();
      w++;
    end
    chk("miss_ready_before_miss", miss_ready_o, 1);
    miss_valid_i = 1'b1;
    miss_addr_i  = a;
    tick();
    miss_valid_i = 1'b0;
    cyc = 1;
  endtask

  task automatic do_ar(input int delay, input logic [31:0] exp_a);
    logic ok = 1'b1;
    for (int d = 0; d <= delay; d++) begin
      if (!(axi_arvalid === 1'b1 && axi_araddr === exp_a && axi_arlen === 8'd7 &&
            axi_arsize === 3'd2 && axi_arburst === 2'd1 && axi_arid === 4'h0 &&
            axi_rready === 1'b0 && miss_ready_o === 1'b0))
        ok = 1'b0;
      if (d == delay) axi_arready = 1'b1;
      tick();
      cyc++;
    end
    axi_arready = 1'b0;
    chk("ar_channel", ok, 1);
  endtask

  task automatic do_beats(input int first, input int last, input logic [31:0] base,
                          input bit gap, input int resp_beat, input logic [1:0] resp_code,
                          input int early, input int bad_id, input bit drop_last);
    logic ok = 1'b1;
    for (int k = first; k <= last; k++) begin
      if (gap) begin
        axi_rvalid = 1'b0;
        if (!(axi_rready === 1'b1 && line_valid_o === 1'b0)) ok = 1'b0;
        tick();
        cyc++;
      end
      axi_rvalid = 1'b1;
      axi_rdata  = base + 32'(k);
      axi_rresp  = (k == resp_beat) ? resp_code : 2'd0;
      axi_rid    = (k == bad_id) ? 4'h5 : 4'h0;
      axi_rlast  = ((k == BEATS - 1) && !drop_last) || (k == early);
      if (!(axi_rready === 1'b1 && axi_arvalid === 1'b0 && line_valid_o === 1'b0)) ok = 1'b0;
      tick();
      cyc++;
    end
    axi_rvalid = 1'b0;
    axi_rlast  = 1'b0;
    axi_rresp  = 2'd0;
    axi_rid    = 4'h0;
    chk("r_channel", ok, 1);
  endtask

  task automatic check_line(input logic [31:0] exp_a, input logic [31:0] base,
                            input bit exp_err, input int exp_lat);
    logic [255:0] exp_d;
    for (int k = 0; k < BEATS; k++) exp_d[32*k +: 32] = base + 32'(k);
    chk("line_valid", line_valid_o, 1);
    if (exp_lat >= 0) chk("latency", cyc, exp_lat);
    chk("line_addr", line_addr_o, exp_a);
    chk("line_data", line_data_o, exp_d);
    chk("line_err", line_err_o, exp_err);
    chk("resp_ready_rready", {miss_ready_o, axi_rready, axi_arvalid}, 3'b000);
  endtask

  task automatic release_line();
    line_ready_i = 1'b1;
    tick();
    line_ready_i = 1'b0;
    chk("idle_after_resp", {miss_ready_o, line_valid_o}, 2'b10);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [255:0] hold_d;
    logic [31:0]  hold_a;
    logic         hold_ok;

    //            addr          ard gap rb  rc    el  bid dl base          araddr        err lat
    vecs[0] = '{32'h0000_104C, 0, 0, -1, 2'd0, -1, -1, 0, 32'h0000_00A0, 32'h0000_1040, 0, 10};
    vecs[1] = '{32'h2000_0123, 5, 1, -1, 2'd0, -1, -1, 0, 32'h0000_0100, 32'h2000_0120, 0, -1};
    vecs[2] = '{32'h3FFF_FFFF, 0, 0,  3, 2'd2, -1, -1, 0, 32'h5500_0000, 32'h3FFF_FFE0, 1, 10};
    vecs[3] = '{32'h0000_0040, 0, 0, -1, 2'd0,  5, -1, 0, 32'h0000_00B0, 32'h0000_0040, 1, 10};
    vecs[4] = '{32'h8000_0008, 2, 0, -1, 2'd0, -1,  6, 0, 32'h0000_00C0, 32'h8000_0000, 1, -1};
    vecs[5] = '{32'h1234_567C, 0, 0, -1, 2'd0, -1, -1, 1, 32'h0000_00D0, 32'h1234_5660, 1, 10};
    vecs[6] = '{32'hFFFF_FFE4, 0, 1,  0, 2'd3, -1, -1, 0, 32'hFFFF_FFFC, 32'hFFFF_FFE0, 1, -1};
    vecs[7] = '{32'h0000_0000, 0, 0, -1, 2'd0, -1, -1, 0, 32'h0000_0001, 32'h0000_0000, 0, 10};
    vecs[8] = '{32'h0000_2A10, 0, 0,  2, 2'd1, -1, -1, 0, 32'h0000_0300, 32'h0000_2A00, 0, 10};

    rst_n        = 1'b0;
    miss_valid_i = 1'b0;
    miss_addr_i  = '0;
    line_ready_i = 1'b0;
    axi_arready  = 1'b0;
    axi_rid      = '0;
    axi_rdata    = '0;
    axi_rresp    = '0;
    axi_rlast    = 1'b0;
    axi_rvalid   = 1'b0;
    tick();
    tick();
    chk("reset_ctrl", {miss_ready_o, axi_arvalid, axi_rready, line_valid_o, line_err_o}, 5'b10000);
    chk("reset_line_addr", line_addr_o, 0);
    chk("reset_line_data", line_data_o, 0);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 9; i++) begin
      do_miss(vecs[i].addr);
      do_ar(vecs[i].ar_delay, vecs[i].exp_araddr);
      do_beats(0, BEATS - 1, vecs[i].base, vecs[i].gap, vecs[i].resp_beat, vecs[i].resp_code,
               vecs[i].early_last, vecs[i].bad_id_beat, vecs[i].drop_last);
      check_line(vecs[i].exp_araddr, vecs[i].base, vecs[i].exp_err, vecs[i].exp_lat);
      release_line();
    end

    // RESP held 4 cycles with the next miss already pending
    do_miss(32'h0000_7788);
    do_ar(0, 32'h0000_7780);
    do_beats(0, BEATS - 1, 32'h0000_0700, 0, -1, 2'd0, -1, -1, 0);
    check_line(32'h0000_7780, 32'h0000_0700, 0, 10);
    hold_d       = line_data_o;
    hold_a       = line_addr_o;
    hold_ok      = 1'b1;
    miss_valid_i = 1'b1;
    miss_addr_i  = 32'h0000_9904;
    for (int c = 0; c < 4; c++) begin
      tick();
      if (!(line_valid_o === 1'b1 && miss_ready_o === 1'b0 && line_data_o === hold_d &&
            line_addr_o === hold_a && line_err_o === 1'b0 && axi_arvalid === 1'b0))
        hold_ok = 1'b0;
    end
    chk("resp_hold_stable", hold_ok, 1);
    line_ready_i = 1'b1;
    tick();
    line_ready_i = 1'b0;
    chk("pending_miss_not_taken_in_resp", {miss_ready_o, axi_arvalid, line_valid_o}, 3'b100);
    tick();
    miss_valid_i = 1'b0;
    cyc = 1;
    chk("pending_miss_taken", {axi_arvalid, axi_araddr}, {1'b1, 32'h0000_9900});
    do_ar(0, 32'h0000_9900);
    do_beats(0, BEATS - 1, 32'h0000_0900, 0, -1, 2'd0, -1, -1, 0);
    check_line(32'h0000_9900, 32'h0000_0900, 0, 10);
    release_line();

    // Reset asserted while beat 4 is on the bus
    do_miss(32'h5000_0010);
    do_ar(0, 32'h5000_0000);
    do_beats(0, 3, 32'h0000_00E0, 0, 2, 2'd2, -1, -1, 0);
    axi_rvalid = 1'b1;
    axi_rdata  = 32'h0000_00E4;
    #2;
    rst_n = 1'b0;
    #1;
    chk("reset_mid_burst_ctrl", {miss_ready_o, axi_arvalid, axi_rready, line_valid_o, line_err_o},
        5'b10000);
    chk("reset_mid_burst_data", line_data_o, 0);
    axi_rvalid = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    do_miss(32'h6000_0004);
    do_ar(0, 32'h6000_0000);
    do_beats(0, BEATS - 1, 32'h0000_00F0, 0, -1, 2'd0, -1, -1, 0);
    check_line(32'h6000_0000, 32'h0000_00F0, 0, 10);
    release_line();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
